// File: rtl/expand_s_ctrl_if.sv
// Polynomial output stream of the ExpandS sequencer: valid/ready handshake plus payload.
interface expand_s_ctrl_if #(
  parameter int N           = 256,
  parameter int COEFF_WIDTH = 4,
  parameter int IDX_W       = 4
);
  logic                       poly_valid;
  logic                       poly_ready;
  logic [IDX_W-1:0]           poly_idx;
  logic                       poly_is_s2;
  logic [N*COEFF_WIDTH-1:0]   poly_data;

  modport master (
    output poly_valid,
    output poly_idx,
    output poly_is_s2,
    output poly_data,
    input  poly_ready
  );

  modport slave (
    input  poly_valid,
    input  poly_idx,
    input  poly_is_s2,
    input  poly_data,
    output poly_ready
  );
endinterface

// File: rtl/expand_s_ctrl.sv
// ExpandS sequencer: drives one bounded-coefficient sampler over s1[0..L-1] then s2[0..K-1].
// Optional EXPAND_S_ABORT_EN adds an abort input and a DRAIN state for an in-flight sampler run.
module expand_s_ctrl #(
  parameter int L           = 7,
  parameter int K           = 8,
  parameter int N           = 256,
  parameter int COEFF_WIDTH = 4,
  parameter int IDX_W       = $clog2(L + K)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [511:0]             rho_prime,
`ifdef EXPAND_S_ABORT_EN
  input  logic                     abort,
`endif
  output logic                     busy,
  output logic                     done,
  expand_s_ctrl_if.master          poly,
  output logic                     sampler_start,
  output logic [527:0]             sampler_seed,
  input  logic                     sampler_done,
  input  logic [N*COEFF_WIDTH-1:0] sampler_poly
);

  localparam logic [15:0] LAST_IDX = 16'(L + K - 1);
  localparam logic [15:0] S2_BASE  = 16'(L);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_OUTPUT = 3'd3,
`ifdef EXPAND_S_ABORT_EN
    ST_DRAIN  = 3'd5,
`endif
    ST_FINISH = 3'd4
  } state_t;

  state_t        state_r;
  logic [15:0]   idx_r;
  logic [511:0]  rho_r;
  logic [15:0]   idx_nxt_s;

  assign idx_nxt_s = idx_r + 16'd1;

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= ST_IDLE;
      idx_r           <= 16'd0;
      rho_r           <= 512'd0;
      busy            <= 1'b0;
      done            <= 1'b0;
      sampler_start   <= 1'b0;
      sampler_seed    <= 528'd0;
      poly.poly_valid <= 1'b0;
      poly.poly_idx   <= {IDX_W{1'b0}};
      poly.poly_is_s2 <= 1'b0;
      poly.poly_data  <= {(N*COEFF_WIDTH){1'b0}};
    end else begin
      sampler_start <= 1'b0;
      done          <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            rho_r         <= rho_prime;
            idx_r         <= 16'd0;
            busy          <= 1'b1;
            sampler_start <= 1'b1;
            sampler_seed  <= {16'd0, rho_prime};
            state_r       <= ST_LAUNCH;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LAUNCH: begin
`ifdef EXPAND_S_ABORT_EN
          if (abort) begin
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_WAIT;
          end
`else
          state_r <= ST_WAIT;
`endif
        end
        ST_WAIT: begin
`ifdef EXPAND_S_ABORT_EN
          // A completion coinciding with abort already counts as drained.
          if (abort && sampler_done) begin
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end else if (abort) begin
            state_r <= ST_DRAIN;
          end else
`endif
          if (sampler_done) begin
            poly.poly_data  <= sampler_poly;
            poly.poly_idx   <= idx_r[IDX_W-1:0];
            poly.poly_is_s2 <= (idx_r >= S2_BASE);
            poly.poly_valid <= 1'b1;
            state_r         <= ST_OUTPUT;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_OUTPUT: begin
`ifdef EXPAND_S_ABORT_EN
          if (abort) begin
            poly.poly_valid <= 1'b0;
            busy            <= 1'b0;
            state_r         <= ST_IDLE;
          end else
`endif
          if (poly.poly_valid && poly.poly_ready) begin
            poly.poly_valid <= 1'b0;
            if (idx_r == LAST_IDX) begin
              done    <= 1'b1;
              busy    <= 1'b0;
              state_r <= ST_FINISH;
            end else begin
              idx_r         <= idx_nxt_s;
              sampler_start <= 1'b1;
              sampler_seed  <= {idx_nxt_s, rho_r};
              state_r       <= ST_LAUNCH;
            end
          end else begin
            state_r <= ST_OUTPUT;
          end
        end
        ST_FINISH: begin
          state_r <= ST_IDLE;
        end
`ifdef EXPAND_S_ABORT_EN
        ST_DRAIN: begin
          if (sampler_done) begin
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
`endif
        default: begin
          busy            <= 1'b0;
          poly.poly_valid <= 1'b0;
          state_r         <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
